// File: rtl/counter_pkg.sv
// Shared types for the reload scheduler:
// FSM states and the queued {match, value} entry.
package counter_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [MAX_W-1:0] match;
    logic [MAX_W-1:0] value;
  } entry_t;

  function automatic logic hit(
    input entry_t           e,
    input logic [MAX_W-1:0] c
  );
    return e.match == c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding packed reload entries.
// Pushes while full are dropped; clr_i empties it.
module sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            data_i,
  output logic [DW-1:0]            data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/load_scheduler.sv
// Queues {match, value} reload requests and strobes
// load for one cycle when the counter hits the head.
module load_scheduler #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_match,
  input  logic [WIDTH-1:0]       req_value,
  input  logic [WIDTH-1:0]       cnt,
  output logic                   load,
  output logic [WIDTH-1:0]       data_load,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   busy
);

  import counter_pkg::*;

  localparam int PW = $clog2(DEPTH) + 1;

  state_e           state_q;
  logic             load_q;
  logic [WIDTH-1:0] data_q;

  logic             push, pop, full, empty;
  logic [PW-1:0]    count;
  logic [2*WIDTH-1:0] head_raw;
  entry_t           head_e;

  assign push = req_valid & ~full & ~flush;
  assign pop  = (state_q == S_FIRE);

  sync_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({req_match, req_value}),
    .data_o  (head_raw),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign head_e.match = MAX_W'(head_raw[2*WIDTH-1:WIDTH]);
  assign head_e.value = MAX_W'(head_raw[WIDTH-1:0]);

  // Remaining entries after the pop, counting a same-edge push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!empty) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (hit(head_e, MAX_W'(cnt))) begin
            state_q <= S_FIRE;
            load_q  <= 1'b1;
            data_q  <= WIDTH'(head_e.value);
          end
        end
        S_FIRE: begin
          load_q  <= 1'b0;
          state_q <= (count > PW'(1) || push)
                     ? S_ARMED : S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          load_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load      = load_q;
  assign data_load = data_q;
  assign pending   = count;
  assign busy      = (count != '0);
  assign req_ready = ~full;

endmodule

// File: tb/tb_load_scheduler.sv
// Directed bench for load_scheduler with a model
// of the downstream loadable counter.
module tb_load_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_match = '0;
  logic [7:0] req_value = '0;
  logic [7:0] cnt = '0;
  logic       load;
  logic [7:0] data_load;
  logic [2:0] pending;
  logic       busy;

  logic       cnt_set = 1'b0;
  logic       cnt_run = 1'b0;
  logic [7:0] cnt_val = '0;

  int n_vec = 0;
  int n_bad = 0;
  int strobes = 0;
  int snap;

  always #5 clk = ~clk;

  load_scheduler #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_match (req_match),
    .req_value (req_value),
    .cnt       (cnt),
    .load      (load),
    .data_load (data_load),
    .pending   (pending),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (cnt_set)      cnt <= cnt_val;
    else if (load)    cnt <= data_load;
    else if (cnt_run) cnt <= cnt + 8'd1;
  end

  always @(posedge clk) begin
    if (load) strobes <= strobes + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    while (!load && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(load), 1);
  endtask

  task automatic offer(input logic [7:0] m,
                       input logic [7:0] v);
    req_valid = 1'b1;
    req_match = m;
    req_value = v;
  endtask

  task automatic set_cnt(input logic [7:0] v);
    cnt_set = 1'b1;
    cnt_val = v;
    tick();
    cnt_set = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_load",  32'(load), 0);
    chk("rst_data",  32'(data_load), 0);
    chk("rst_pend",  32'(pending), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 1);

    // single request
    cnt_set = 1'b1; cnt_val = 8'd0; cnt_run = 1'b1;
    offer(8'd5, 8'd20);
    tick();
    cnt_set = 1'b0; req_valid = 1'b0;
    chk("t1_pend1", 32'(pending), 1);
    chk("t1_busy",  32'(busy), 1);
    wait_load("t1");
    chk("t1_cnt6",  32'(cnt), 6);
    chk("t1_data",  32'(data_load), 20);
    chk("t1_pfire", 32'(pending), 1);
    tick();
    chk("t1_cnt20", 32'(cnt), 20);
    chk("t1_loadlo", 32'(load), 0);
    chk("t1_pend0", 32'(pending), 0);
    chk("t1_busy0", 32'(busy), 0);
    chk("t1_hold",  32'(data_load), 20);

    // ordered, back-to-back fire
    snap = strobes;
    cnt_set = 1'b1; cnt_val = 8'd0;
    offer(8'd5, 8'd20);
    tick();
    cnt_set = 1'b0;
    offer(8'd20, 8'd3);
    tick();
    req_valid = 1'b0;
    chk("t2_pend2", 32'(pending), 2);
    wait_load("t2a");
    chk("t2_cnt6",  32'(cnt), 6);
    chk("t2_data1", 32'(data_load), 20);
    tick();
    chk("t2_gap",   32'(load), 0);
    chk("t2_cnt20", 32'(cnt), 20);
    chk("t2_pend1", 32'(pending), 1);
    tick();
    chk("t2_load2", 32'(load), 1);
    chk("t2_data2", 32'(data_load), 3);
    tick();
    chk("t2_cnt3",  32'(cnt), 3);
    chk("t2_pend0", 32'(pending), 0);
    repeat (10) tick();
    chk("t2_strobes", 32'(strobes - snap), 2);

    // full queue, then flush during FIRE
    cnt_run = 1'b0;
    cnt_set = 1'b1; cnt_val = 8'd200;
    offer(8'd210, 8'd1);
    tick();
    cnt_set = 1'b0;
    offer(8'd211, 8'd2); tick();
    offer(8'd212, 8'd3); tick();
    offer(8'd213, 8'd4); tick();
    chk("t3_ready0", 32'(req_ready), 0);
    chk("t3_pend4",  32'(pending), 4);
    offer(8'd214, 8'd5); tick();
    req_valid = 1'b0;
    chk("t3_ign",    32'(pending), 4);
    set_cnt(8'd210);
    wait_load("t3a");
    chk("t3_data1",  32'(data_load), 1);
    chk("t3_rdyf",   32'(req_ready), 0);
    tick();
    chk("t3_pend3",  32'(pending), 3);
    chk("t3_ready1", 32'(req_ready), 1);
    set_cnt(8'd211);
    wait_load("t3b");
    chk("t3_data2",  32'(data_load), 2);
    chk("t3_pfire",  32'(pending), 3);
    flush = 1'b1;
    offer(8'd99, 8'd99);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("fl_load",  32'(load), 0);
    chk("fl_pend",  32'(pending), 0);
    chk("fl_busy",  32'(busy), 0);
    chk("fl_ready", 32'(req_ready), 1);
    snap = strobes;
    set_cnt(8'd212);
    repeat (5) tick();
    chk("fl_quiet", 32'(strobes - snap), 0);
    chk("fl_pend2", 32'(pending), 0);

    // reset during FIRE
    offer(8'd50, 8'd7); tick();
    offer(8'd51, 8'd8); tick();
    offer(8'd52, 8'd9); tick();
    req_valid = 1'b0;
    set_cnt(8'd50);
    wait_load("rf");
    chk("rf_data",  32'(data_load), 7);
    chk("rf_pfire", 32'(pending), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_load",  32'(load), 0);
    chk("rf_dl",    32'(data_load), 0);
    chk("rf_pend",  32'(pending), 0);
    chk("rf_busy",  32'(busy), 0);
    chk("rf_ready", 32'(req_ready), 1);

    // counter wrap
    cnt_set = 1'b1; cnt_val = 8'd250; cnt_run = 1'b1;
    offer(8'd0, 8'd100);
    tick();
    cnt_set = 1'b0; req_valid = 1'b0;
    wait_load("wr");
    chk("wr_cnt1",  32'(cnt), 1);
    chk("wr_data",  32'(data_load), 100);
    tick();
    chk("wr_cnt100", 32'(cnt), 100);

    // push on the FIRE-exit edge
    cnt_run = 1'b0;
    cnt_set = 1'b1; cnt_val = 8'd0;
    offer(8'd60, 8'd11);
    tick();
    cnt_set = 1'b0;
    offer(8'd61, 8'd12);
    tick();
    req_valid = 1'b0;
    set_cnt(8'd60);
    wait_load("pp");
    chk("pp_data1", 32'(data_load), 11);
    chk("pp_pend2", 32'(pending), 2);
    offer(8'd62, 8'd13);
    tick();
    req_valid = 1'b0;
    chk("pp_hold2", 32'(pending), 2);
    set_cnt(8'd61);
    wait_load("pp2");
    chk("pp_data2", 32'(data_load), 12);
    tick();
    set_cnt(8'd62);
    wait_load("pp3");
    chk("pp_data3", 32'(data_load), 13);
    chk("pp_pend1", 32'(pending), 1);
    tick();
    chk("pp_pend0", 32'(pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
